// File: rtl/axi_bridge_pkg.sv
// axi_bridge_pkg: shared state encodings, AXI constants and line-offset helper for the AXI bridge
package axi_bridge_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wstate_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;

    function automatic int line_off(input int line_words);
        return $clog2(line_words * 4);
    endfunction

endpackage

// File: rtl/axi_wr_serializer.sv
// axi_wr_serializer: walks a latched cache line out on the W channel, one word per wready beat
module axi_wr_serializer
    import axi_bridge_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         start,
    input  logic                         active,
    input  logic [DATA_W*LINE_WORDS-1:0] line,
    input  logic [7:0]                   len,
    input  logic [DATA_W/8-1:0]          strb,
    input  logic                         wready,
    output logic                         wvalid,
    output logic [DATA_W-1:0]            wdata,
    output logic [DATA_W/8-1:0]          wstrb,
    output logic                         wlast,
    output logic                         fire_last
);

    localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] words [LINE_WORDS];

    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_words
        assign words[i] = line[i*DATA_W +: DATA_W];
    end

    assign wvalid    = active;
    assign wdata     = words[cnt];
    assign wstrb     = (len == 8'd0) ? strb : '1;
    assign wlast     = 8'(cnt) == len;
    assign fire_last = active && wready && wlast;

    // beat counter: cleared when a new line is accepted, advances on every W handshake
    always_ff @(posedge aclk) begin
        if (!aresetn || start) cnt <= '0;
        else if (active && wready) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/axi_bridge.sv
// axi_bridge: single AXI3 master shared by I-cache refill, D-cache refill and D-cache write-back
module axi_bridge
    import axi_bridge_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         inst_rd_req,
    input  logic [ADDR_W-1:0]            inst_rd_addr,
    input  logic [7:0]                   inst_rd_len,
    output logic                         inst_rd_rdy,
    output logic                         inst_ret_valid,
    output logic                         inst_ret_last,
    output logic [DATA_W-1:0]            inst_ret_data,
    input  logic                         data_rd_req,
    input  logic [ADDR_W-1:0]            data_rd_addr,
    input  logic [7:0]                   data_rd_len,
    input  logic [2:0]                   data_rd_size,
    output logic                         data_rd_rdy,
    output logic                         data_ret_valid,
    output logic                         data_ret_last,
    output logic [DATA_W-1:0]            data_ret_data,
    input  logic                         data_wr_req,
    input  logic [ADDR_W-1:0]            data_wr_addr,
    input  logic [7:0]                   data_wr_len,
    input  logic [2:0]                   data_wr_size,
    input  logic [DATA_W/8-1:0]          data_wr_strb,
    input  logic [DATA_W*LINE_WORDS-1:0] data_wr_data,
    output logic                         data_wr_rdy,
    output logic                         data_wr_done,
    output logic [3:0]                   arid,
    output logic [ADDR_W-1:0]            araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic [1:0]                   arlock,
    output logic [3:0]                   arcache,
    output logic [2:0]                   arprot,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [3:0]                   rid,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,
    output logic [3:0]                   awid,
    output logic [ADDR_W-1:0]            awaddr,
    output logic [7:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic [1:0]                   awlock,
    output logic [3:0]                   awcache,
    output logic [2:0]                   awprot,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [3:0]                   wid,
    output logic [DATA_W-1:0]            wdata,
    output logic [DATA_W/8-1:0]          wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [3:0]                   bid,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready
);

    localparam int         OFF = line_off(LINE_WORDS);
    localparam logic [7:0] LW  = 8'(LINE_WORDS - 1);

    rstate_t                     rstate, rstate_n;
    wstate_t                     wstate, wstate_n;
    logic [ADDR_W-1:0]           rd_addr_q, wr_addr_q;
    logic [7:0]                  rd_len_q, wr_len_q;
    logic [2:0]                  rd_size_q, wr_size_q;
    logic                        rd_owner_q;
    logic [DATA_W/8-1:0]         wr_strb_q;
    logic [DATA_W*LINE_WORDS-1:0] wr_line_q;
    logic                        done_q;
    logic                        haz_d, haz_i, data_acc, inst_acc, wr_acc, fire_last;
    logic                        unused;

    assign unused = ^{rid, rresp, bid, bresp};

    // a read may not overtake a write-back that is still in flight to the same line
    assign haz_d = (wstate != W_IDLE) && (data_rd_addr[ADDR_W-1:OFF] == wr_addr_q[ADDR_W-1:OFF]);
    assign haz_i = (wstate != W_IDLE) && (inst_rd_addr[ADDR_W-1:OFF] == wr_addr_q[ADDR_W-1:OFF]);

    assign data_rd_rdy = aresetn && (rstate == R_IDLE) && !haz_d;
    assign inst_rd_rdy = aresetn && (rstate == R_IDLE) && !data_rd_req && !haz_i;
    assign data_wr_rdy = aresetn && (wstate == W_IDLE);
    assign data_acc    = data_rd_req && data_rd_rdy;
    assign inst_acc    = inst_rd_req && inst_rd_rdy;
    assign wr_acc      = data_wr_req && data_wr_rdy;

    assign arid    = rd_owner_q ? ID_DATA : ID_INST;
    assign araddr  = rd_addr_q;
    assign arlen   = rd_len_q;
    assign arsize  = rd_size_q;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    assign awid    = ID_DATA;
    assign wid     = ID_DATA;
    assign awaddr  = wr_addr_q;
    assign awlen   = wr_len_q;
    assign awsize  = wr_size_q;
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;

    assign inst_ret_data = rdata;
    assign data_ret_data = rdata;
    assign inst_ret_last = rlast;
    assign data_ret_last = rlast;
    assign data_wr_done  = done_q;

    // read state register and the request latch taken on accept
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rstate     <= R_IDLE;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_size_q  <= '0;
            rd_owner_q <= 1'b0;
        end else begin
            rstate <= rstate_n;
            if (data_acc || inst_acc) begin
                rd_addr_q  <= data_acc ? data_rd_addr : inst_rd_addr;
                rd_len_q   <= data_acc ? data_rd_len : inst_rd_len;
                rd_size_q  <= data_acc ? data_rd_size : 3'b010;
                rd_owner_q <= data_acc;
            end
        end
    end

    // read next-state and channel outputs; R beats are routed to the latched owner
    always_comb begin
        rstate_n       = rstate;
        arvalid        = rstate == R_AR;
        rready         = rstate == R_DATA;
        inst_ret_valid = (rstate == R_DATA) && rvalid && !rd_owner_q;
        data_ret_valid = (rstate == R_DATA) && rvalid && rd_owner_q;
        unique case (rstate)
            R_IDLE:  rstate_n = (data_acc || inst_acc) ? R_AR : R_IDLE;
            R_AR:    rstate_n = arready ? R_DATA : R_AR;
            R_DATA:  rstate_n = (rvalid && rlast) ? R_IDLE : R_DATA;
            default: rstate_n = R_IDLE;
        endcase
    end

    // write state register, latched line/request and the B-response done pulse
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate    <= W_IDLE;
            wr_addr_q <= '0;
            wr_len_q  <= '0;
            wr_size_q <= '0;
            wr_strb_q <= '0;
            wr_line_q <= '0;
            done_q    <= 1'b0;
        end else begin
            wstate <= wstate_n;
            done_q <= (wstate == W_B) && bvalid;
            if (wr_acc) begin
                wr_addr_q <= data_wr_addr;
                wr_len_q  <= (data_wr_len > LW) ? LW : data_wr_len;
                wr_size_q <= data_wr_size;
                wr_strb_q <= data_wr_strb;
                wr_line_q <= data_wr_data;
            end
        end
    end

    // write next-state and AW/B handshake outputs
    always_comb begin
        wstate_n = wstate;
        awvalid  = wstate == W_AW;
        bready   = wstate == W_B;
        unique case (wstate)
            W_IDLE:  wstate_n = wr_acc ? W_AW : W_IDLE;
            W_AW:    wstate_n = awready ? W_DATA : W_AW;
            W_DATA:  wstate_n = fire_last ? W_B : W_DATA;
            W_B:     wstate_n = bvalid ? W_IDLE : W_B;
            default: wstate_n = W_IDLE;
        endcase
    end

    axi_wr_serializer #(.DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) u_ser (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (wr_acc),
        .active    (wstate == W_DATA),
        .line      (wr_line_q),
        .len       (wr_len_q),
        .strb      (wr_strb_q),
        .wready    (wready),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .fire_last (fire_last)
    );

endmodule

// File: tb/tb_axi_bridge.sv
// tb_axi_bridge: directed scenarios for the shared AXI master bridge
module tb_axi_bridge;

    logic         aclk = 1'b0, aresetn = 1'b0;
    logic         inst_rd_req, inst_rd_rdy, inst_ret_valid, inst_ret_last;
    logic [31:0]  inst_rd_addr, inst_ret_data;
    logic [7:0]   inst_rd_len;
    logic         data_rd_req, data_rd_rdy, data_ret_valid, data_ret_last;
    logic [31:0]  data_rd_addr, data_ret_data;
    logic [7:0]   data_rd_len;
    logic [2:0]   data_rd_size;
    logic         data_wr_req, data_wr_rdy, data_wr_done;
    logic [31:0]  data_wr_addr;
    logic [7:0]   data_wr_len;
    logic [2:0]   data_wr_size;
    logic [3:0]   data_wr_strb;
    logic [127:0] data_wr_data;
    logic [3:0]   arid, arcache, awid, awcache, wid, rid, bid;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, arprot, awsize, awprot;
    logic [1:0]   arburst, arlock, awburst, awlock, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axi_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_rd_req(inst_rd_req), .inst_rd_addr(inst_rd_addr), .inst_rd_len(inst_rd_len),
        .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
        .inst_ret_data(inst_ret_data),
        .data_rd_req(data_rd_req), .data_rd_addr(data_rd_addr), .data_rd_len(data_rd_len),
        .data_rd_size(data_rd_size), .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid),
        .data_ret_last(data_ret_last), .data_ret_data(data_ret_data),
        .data_wr_req(data_wr_req), .data_wr_addr(data_wr_addr), .data_wr_len(data_wr_len),
        .data_wr_size(data_wr_size), .data_wr_strb(data_wr_strb), .data_wr_data(data_wr_data),
        .data_wr_rdy(data_wr_rdy), .data_wr_done(data_wr_done),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic step;
        @(posedge aclk);
        #2;
    endtask

    task automatic idle_inputs;
        inst_rd_req = 0; inst_rd_addr = 0; inst_rd_len = 0;
        data_rd_req = 0; data_rd_addr = 0; data_rd_len = 0; data_rd_size = 3'd2;
        data_wr_req = 0; data_wr_addr = 0; data_wr_len = 0; data_wr_size = 3'd2;
        data_wr_strb = 4'hF; data_wr_data = '0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    endtask

    task automatic wr_to_b(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb);
        int n;
        data_wr_req = 1; data_wr_addr = addr; data_wr_len = len; data_wr_strb = strb;
        data_wr_data = {32'd4, 32'd3, 32'd2, 32'd1};
        step;
        data_wr_req = 0; awready = 1;
        step;
        awready = 0; wready = 1;
        n = 0;
        while (!bready && n < 20) begin step; n++; end
        wready = 0;
        if (!bready) begin errors++; $display("FAIL wr_to_b_timeout: bready=%0b required 1", bready); end
    endtask

    task automatic finish_b;
        bvalid = 1;
        step;
        bvalid = 0;
    endtask

    task automatic rd_finish(input int beats);
        arready = 1;
        step;
        arready = 0;
        for (int i = 0; i < beats; i++) begin
            rvalid = 1; rlast = (i == beats - 1); rdata = 32'h5000 + i;
            step;
        end
        rvalid = 0; rlast = 0;
    endtask

    task automatic test_reset;
        inst_rd_req = 1; inst_rd_addr = 32'h40; inst_rd_len = 3;
        data_wr_req = 1; data_wr_addr = 32'h1000; data_wr_len = 0;
        step;
        inst_rd_req = 0; data_wr_req = 0; arready = 1;
        step;
        arready = 0; rvalid = 1; rdata = 32'h1; rlast = 0;
        #1;
        checks++; if ({rready, awvalid} !== 2'b11) begin errors++; $display("FAIL reset_pre_busy: got %b required 11", {rready, awvalid}); end
        step;
        aresetn = 0; rvalid = 0;
        step;
        #1;
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, inst_rd_rdy, data_rd_rdy, data_wr_rdy,
             inst_ret_valid, data_ret_valid, data_wr_done} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {arvalid, rready, awvalid, wvalid, bready,
                     inst_rd_rdy, data_rd_rdy, data_wr_rdy, inst_ret_valid, data_ret_valid, data_wr_done});
        end
        checks++; if ({araddr, arlen, awaddr} !== 72'b0) begin errors++; $display("FAIL reset_latches: got %h required 0", {araddr, arlen, awaddr}); end
        step; step;
        aresetn = 1;
        #1;
        checks++; if ({inst_rd_rdy, data_rd_rdy, data_wr_rdy, arvalid, awvalid} !== 5'b11100) begin errors++; $display("FAIL reset_release: got %b required 11100", {inst_rd_rdy, data_rd_rdy, data_wr_rdy, arvalid, awvalid}); end
        step;
    endtask

    task automatic test_inst_read;
        inst_rd_req = 1; inst_rd_addr = 32'h1C000040; inst_rd_len = 3;
        #1;
        checks++; if (inst_rd_rdy !== 1'b1) begin errors++; $display("FAIL ird_rdy: got %b required 1", inst_rd_rdy); end
        step;
        inst_rd_req = 0;
        for (int c = 0; c < 3; c++) begin
            arready = (c == 2);
            #1;
            checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL ird_arvalid_held c=%0d: got %b required 1", c, arvalid); end
            if (c == 0) begin
                checks++;
                if ({arid, araddr, arlen, arsize, arburst} !== {4'd0, 32'h1C000040, 8'd3, 3'd2, 2'b01}) begin
                    errors++;
                    $display("FAIL ird_ar_fields: got %h %h %h %h %h required 0 1c000040 03 2 1", arid, araddr, arlen, arsize, arburst);
                end
            end
            step;
        end
        arready = 0;
        #1;
        checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL ird_rdata_state: got %b required 01", {arvalid, rready}); end
        for (int i = 0; i < 4; i++) begin
            rvalid = 1; rdata = 32'hA0 + i; rlast = (i == 3);
            #1;
            checks++;
            if ({inst_ret_valid, inst_ret_last, data_ret_valid, inst_ret_data} !== {1'b1, (i == 3), 1'b0, 32'hA0 + i}) begin
                errors++;
                $display("FAIL ird_beat%0d: got v=%b l=%b dv=%b d=%h required v=1 l=%0b dv=0 d=%h", i, inst_ret_valid, inst_ret_last, data_ret_valid, inst_ret_data, i == 3, 32'hA0 + i);
            end
            step;
        end
        rvalid = 0; rlast = 0;
        #1;
        checks++; if ({inst_rd_rdy, rready} !== 2'b10) begin errors++; $display("FAIL ird_back_idle: got %b required 10", {inst_rd_rdy, rready}); end
    endtask

    task automatic test_priority;
        inst_rd_req = 1; inst_rd_addr = 32'h100; inst_rd_len = 0;
        data_rd_req = 1; data_rd_addr = 32'h200; data_rd_len = 0; data_rd_size = 3'd2;
        #1;
        checks++; if ({data_rd_rdy, inst_rd_rdy} !== 2'b10) begin errors++; $display("FAIL prio_rdy: got %b required 10", {data_rd_rdy, inst_rd_rdy}); end
        step;
        data_rd_req = 0;
        #1;
        checks++; if ({arvalid, arid, araddr, inst_rd_rdy} !== {1'b1, 4'd1, 32'h200, 1'b0}) begin errors++; $display("FAIL prio_data_ar: got v=%b id=%h a=%h irdy=%b required v=1 id=1 a=200 irdy=0", arvalid, arid, araddr, inst_rd_rdy); end
        arready = 1;
        step;
        arready = 0; rvalid = 1; rlast = 1; rdata = 32'hD0;
        #1;
        checks++; if ({data_ret_valid, data_ret_last, data_ret_data, inst_ret_valid, inst_rd_rdy} !== {2'b11, 32'hD0, 2'b00}) begin errors++; $display("FAIL prio_data_ret: got dv=%b dl=%b d=%h iv=%b irdy=%b required 1 1 d0 0 0", data_ret_valid, data_ret_last, data_ret_data, inst_ret_valid, inst_rd_rdy); end
        step;
        rvalid = 0; rlast = 0;
        #1;
        checks++; if (inst_rd_rdy !== 1'b1) begin errors++; $display("FAIL prio_inst_rdy: got %b required 1", inst_rd_rdy); end
        step;
        inst_rd_req = 0;
        #1;
        checks++; if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'h100, 3'd2}) begin errors++; $display("FAIL prio_inst_ar: got v=%b id=%h a=%h s=%h required 1 0 100 2", arvalid, arid, araddr, arsize); end
        arready = 1;
        step;
        arready = 0; rvalid = 1; rlast = 1; rdata = 32'hE0;
        #1;
        checks++; if ({inst_ret_valid, data_ret_valid, inst_ret_data} !== {2'b10, 32'hE0}) begin errors++; $display("FAIL prio_inst_ret: got iv=%b dv=%b d=%h required 1 0 e0", inst_ret_valid, data_ret_valid, inst_ret_data); end
        step;
        rvalid = 0; rlast = 0;
    endtask

    task automatic test_write;
        int beat, n;
        data_wr_req = 1; data_wr_addr = 32'h80; data_wr_len = 3; data_wr_strb = 4'hF; data_wr_size = 3'd2;
        data_wr_data = {32'd4, 32'd3, 32'd2, 32'd1};
        #1;
        checks++; if (data_wr_rdy !== 1'b1) begin errors++; $display("FAIL wr_rdy: got %b required 1", data_wr_rdy); end
        step;
        data_wr_req = 0;
        #1;
        checks++; if ({awvalid, awid, awaddr, awlen, awsize, awburst} !== {1'b1, 4'd1, 32'h80, 8'd3, 3'd2, 2'b01}) begin errors++; $display("FAIL wr_aw_fields: got v=%b id=%h a=%h l=%h s=%h b=%h required 1 1 80 03 2 1", awvalid, awid, awaddr, awlen, awsize, awburst); end
        awready = 1;
        step;
        awready = 0;
        beat = 0; n = 0;
        while (beat < 4 && n < 20) begin
            wready = n[0];
            #1;
            checks++;
            if ({wvalid, wid, wdata, wstrb, wlast} !== {1'b1, 4'd1, 32'(beat + 1), 4'hF, (beat == 3)}) begin
                errors++;
                $display("FAIL wr_beat%0d: got v=%b id=%h d=%h s=%h l=%b required 1 1 %h f %0b", beat, wvalid, wid, wdata, wstrb, wlast, beat + 1, beat == 3);
            end
            if (wready) beat++;
            step;
            n++;
        end
        wready = 0;
        checks++; if (beat !== 4) begin errors++; $display("FAIL wr_beats_timeout: got %0d required 4", beat); end
        #1;
        checks++; if ({wvalid, bready, data_wr_done} !== 3'b010) begin errors++; $display("FAIL wr_in_b: got %b required 010", {wvalid, bready, data_wr_done}); end
        bvalid = 1;
        #1;
        checks++; if (data_wr_done !== 1'b0) begin errors++; $display("FAIL wr_done_early: got %b required 0", data_wr_done); end
        step;
        bvalid = 0;
        #1;
        checks++; if ({data_wr_done, data_wr_rdy} !== 2'b11) begin errors++; $display("FAIL wr_done_pulse: got %b required 11", {data_wr_done, data_wr_rdy}); end
        step;
        #1;
        checks++; if (data_wr_done !== 1'b0) begin errors++; $display("FAIL wr_done_once: got %b required 0", data_wr_done); end
    endtask

    task automatic test_hazard;
        wr_to_b(32'h80, 8'd0, 4'hF);
        data_rd_req = 1; data_rd_addr = 32'h84; data_rd_len = 0;
        #1;
        checks++; if (data_rd_rdy !== 1'b0) begin errors++; $display("FAIL haz_block0: got %b required 0", data_rd_rdy); end
        step;
        #1;
        checks++; if (data_rd_rdy !== 1'b0) begin errors++; $display("FAIL haz_block1: got %b required 0", data_rd_rdy); end
        bvalid = 1;
        #1;
        checks++; if (data_rd_rdy !== 1'b0) begin errors++; $display("FAIL haz_block_bvalid: got %b required 0", data_rd_rdy); end
        step;
        bvalid = 0;
        #1;
        checks++; if (data_rd_rdy !== 1'b1) begin errors++; $display("FAIL haz_release: got %b required 1", data_rd_rdy); end
        step;
        data_rd_req = 0;
        #1;
        checks++; if ({arvalid, araddr} !== {1'b1, 32'h84}) begin errors++; $display("FAIL haz_read_issued: got v=%b a=%h required 1 84", arvalid, araddr); end
        rd_finish(1);
        wr_to_b(32'h80, 8'd0, 4'hF);
        data_rd_req = 1; data_rd_addr = 32'hC0;
        #1;
        checks++; if (data_rd_rdy !== 1'b1) begin errors++; $display("FAIL haz_other_line: got %b required 1", data_rd_rdy); end
        step;
        data_rd_req = 0;
        #1;
        checks++; if ({arvalid, araddr, bready} !== {1'b1, 32'hC0, 1'b1}) begin errors++; $display("FAIL haz_other_issued: got v=%b a=%h b=%b required 1 c0 1", arvalid, araddr, bready); end
        rd_finish(1);
        finish_b;
        step;
    endtask

    task automatic test_single_and_clamp;
        int beats, lasts, last_at, n;
        data_wr_req = 1; data_wr_addr = 32'h300; data_wr_len = 0; data_wr_strb = 4'b0010;
        data_wr_data = {32'd0, 32'd0, 32'd0, 32'hCAFE};
        step;
        data_wr_req = 0; awready = 1;
        step;
        awready = 0; wready = 1;
        #1;
        checks++; if ({wvalid, wlast, wstrb, wdata} !== {2'b11, 4'b0010, 32'hCAFE}) begin errors++; $display("FAIL single_beat: got v=%b l=%b s=%b d=%h required 1 1 0010 cafe", wvalid, wlast, wstrb, wdata); end
        step;
        wready = 0;
        #1;
        checks++; if ({wvalid, bready} !== 2'b01) begin errors++; $display("FAIL single_to_b: got %b required 01", {wvalid, bready}); end
        finish_b;
        step;
        data_wr_req = 1; data_wr_addr = 32'h400; data_wr_len = 9; data_wr_strb = 4'b0001;
        data_wr_data = {32'd4, 32'd3, 32'd2, 32'd1};
        step;
        data_wr_req = 0;
        #1;
        checks++; if (awlen !== 8'd3) begin errors++; $display("FAIL clamp_awlen: got %0d required 3", awlen); end
        awready = 1;
        step;
        awready = 0; wready = 1;
        beats = 0; lasts = 0; last_at = 0; n = 0;
        while (!bready && n < 20) begin
            if (wvalid) beats++;
            if (wvalid && wlast) begin lasts++; last_at = beats; end
            if (beats == 1) begin
                checks++; if (wstrb !== 4'hF) begin errors++; $display("FAIL clamp_wstrb: got %b required 1111", wstrb); end
            end
            step;
            n++;
        end
        wready = 0;
        checks++; if ({beats, lasts, last_at} !== {32'd4, 32'd1, 32'd4}) begin errors++; $display("FAIL clamp_beats: got beats=%0d lasts=%0d last_at=%0d required 4 1 4", beats, lasts, last_at); end
        finish_b;
        step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        repeat (3) step;
        aresetn = 1;
        step;
        test_reset();
        test_inst_read();
        test_priority();
        test_write();
        test_hazard();
        test_single_and_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_bridge.md
Name: axi_bridge

Overview:
- Single AXI3 master port shared by the instruction-cache refill path, the data-cache refill path and the data-cache write-back path.
- Sits between the core's cache side and the SoC AXI interconnect.
- The top-level AXI pins are driven directly from this block.
- One outstanding read and one outstanding write at a time; read-after-write hazards on the same cache line are blocked.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, AXI data width.
- LINE_WORDS, 4, words per cache line; maximum burst is LINE_WORDS beats.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- inst_rd_req / inst_rd_addr / inst_rd_len  in  1/ADDR_W/8  I-cache read request; len = beats-1
- inst_rd_rdy  out  1  request accepted when req&&rdy
- inst_ret_valid / inst_ret_last / inst_ret_data  out  1/1/DATA_W  I-cache return beats
- data_rd_req / data_rd_addr / data_rd_len / data_rd_size  in  1/ADDR_W/8/3  D-cache read request
- data_rd_rdy  out  1  D-cache read accept
- data_ret_valid / data_ret_last / data_ret_data  out  1/1/DATA_W  D-cache return beats
- data_wr_req / data_wr_addr / data_wr_len / data_wr_size / data_wr_strb  in  1/ADDR_W/8/3/4  write request
- data_wr_data  in  DATA_W*LINE_WORDS  line data; word 0 in LSBs
- data_wr_rdy  out  1  write accept
- data_wr_done  out  1  one-cycle pulse on B response
- arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  out  4,32,8,3,2,2,4,3,1  AR channel
- arready  in  1
- rid, rdata, rresp, rlast, rvalid  in  4,32,2,1,1  R channel
- rready  out  1
- awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  out  4,32,8,3,2,2,4,3,1  AW channel
- awready  in  1
- wid, wdata, wstrb, wlast, wvalid  out  4,32,4,1,1  W channel
- wready  in  1
- bid, bresp, bvalid  in  4,2,1  B channel
- bready  out  1

Behaviour:
- Reset is synchronous on aresetn==0 at the aclk edge.
  - Both FSMs return to idle.
  - All valid, ready and done outputs are 0.
  - Latched address, len, size, owner and beat counter are 0.
- Reset mid-transaction abandons it silently; the interconnect is reset together with this block.
- Constant outputs:
  - arburst=awburst=2'b01 (INCR); lock, cache and prot are 0.
  - awid=wid=1; arid=0 for an instruction read, 1 for a data read.
  - Instruction reads use arsize=3'b010.
- Read FSM: R_IDLE -> R_AR -> R_DATA -> R_IDLE.
  - In R_IDLE: data_rd_rdy = !hazard(data_rd_addr). inst_rd_rdy = !data_rd_req && !hazard(inst_rd_addr).
  - Data has priority when both requests are raised in the same cycle.
  - On accept: latch addr, len, size and owner; go to R_AR.
  - R_AR: arvalid=1 with the latched fields. Move to R_DATA in the cycle after arvalid&&arready.
  - R_DATA: rready=1. Each rvalid beat is forwarded combinationally to the owner's ret port (valid, data, last=rlast).
  - Return latency is zero cycles from rvalid.
  - On rvalid&&rlast, go to R_IDLE. A new request may be accepted the following cycle.
  - rid and rresp are ignored; routing uses the latched owner.
- Write FSM: W_IDLE -> W_AW -> W_DATA -> W_B -> W_IDLE.
  - data_wr_rdy = (state==W_IDLE). On accept, latch the line, addr, len, size and strb.
  - len greater than LINE_WORDS-1 is clamped to LINE_WORDS-1.
  - W_AW: awvalid=1 until awready.
  - W_DATA: wvalid=1; wdata = word[cnt]; wstrb = latched strb when len==0, else 4'hF.
  - wlast=(cnt==len). cnt increments on wvalid&&wready.
  - On the last handshake, go to W_B.
  - W_B: bready=1. On bvalid, pulse data_wr_done and go to W_IDLE. bid and bresp are ignored.
- Hazard: hazard(a) = (wstate!=W_IDLE) && a[ADDR_W-1:OFF] == wr_addr_q[ADDR_W-1:OFF], where OFF = log2(LINE_WORDS*4).
  - A read to the line being written is not accepted until the write returns to W_IDLE.
- Read and write FSMs operate concurrently and independently.
- Simultaneous accept of a data write and a data read to the same line in the same cycle: the read is accepted.
  - The hazard compares only the latched write, so the read proceeds first. The D-cache guarantees this does not occur for dirty victims.

Decomposition:
- Package axi_bridge_pkg holds:
  - Read-state and write-state enums.
  - AXI constants: BURST_INCR, ID_INST=0, ID_DATA=1.
  - The OFF localparam function.
- Sub-module axi_wr_serializer: the W_DATA beat counter and line mux, isolated from the rest of the write FSM.
- Read path stays in the top module.

Test Plan:
- Reset held 3 cycles mid-burst -> every valid/ready output is 0 the cycle after the first reset edge; FSMs idle after release.
- I-read addr 0x1C000040 len 3, arready delayed 2 cycles -> arvalid held 3 cycles; arid 0; arlen 3; 4 inst_ret beats, last on beat 4; data_ret_valid stays 0.
- inst_rd_req and data_rd_req both high at 0x100 and 0x200 -> data accepted first (arid 1); inst accepted the cycle after data rlast.
- Write line 0x80 len 3 data {4,3,2,1}, wready toggling -> wdata sequence 1,2,3,4; wlast only on 4; data_wr_done pulses once, one cycle after bvalid.
- Write to 0x80 in W_B, data read 0x84 -> data_rd_rdy=0 until the cycle after bvalid; read 0xC0 in the same window is accepted immediately.
- Single-word write len 0 strb 4'b0010 -> one beat with wlast=1 and wstrb 4'b0010; write len 9 -> 4 beats (clamped).
